// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_pkg
//  Description : Register offsets, constants and priority helper for irq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int          MAX_SRC        = 8;
    localparam logic [7:0]  VEC_NONE       = 8'h80;

    localparam logic [2:0]  IRQ_REG_STATUS  = 3'd0;
    localparam logic [2:0]  IRQ_REG_PENDING = 3'd1;
    localparam logic [2:0]  IRQ_REG_MASK    = 3'd2;
    localparam logic [2:0]  IRQ_REG_VECTOR  = 3'd3;
    localparam logic [2:0]  IRQ_REG_EDGE    = 3'd4;

    // Lowest-numbered active bit wins; VEC_NONE when nothing is active.
    function automatic logic [7:0] irq_vector(input logic [MAX_SRC-1:0] active);
        logic [7:0] vec;
        vec = VEC_NONE;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec = {5'b00000, 3'(i)};
            end
        end
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : Multi-flop synchroniser for active-low IRQ lines, preset to
//                the deasserted level (1) while in reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] async_n_i,
    output logic [WIDTH-1:0] sync_n_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '1;
            end
        end else begin
            stage_q[0] <= async_n_i;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign sync_n_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : 6502 interrupt controller: synchronised sources, pending/mask
//                registers, priority vector and registered active-low IRQB.
//                Optional edge-latched sources with macro IRQ_CTRL_EDGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC  = 8,
    parameter int SYNC_LEN = 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               cs_n_i,
    input  logic               rw_i,
    input  logic [2:0]         addr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o,
    output logic               rdata_oe_o,
    input  logic [NUM_SRC-1:0] src_irq_n_i,
    output logic               irq_n_o
);

    localparam logic [MAX_SRC-1:0] SRC_VALID = MAX_SRC'((9'd1 << NUM_SRC) - 9'd1);

    logic [NUM_SRC-1:0] w_synced_n;
    logic [NUM_SRC-1:0] w_raw_src;
    logic [MAX_SRC-1:0] w_raw;
    logic               w_wr_act;
    logic               w_commit;
    logic [7:0]         w_rdata;

    logic               wr_act_q;
    logic [MAX_SRC-1:0] mask_q;
    logic [MAX_SRC-1:0] mask_d;
    logic [MAX_SRC-1:0] pending_q;
    logic [MAX_SRC-1:0] pending_d;
    logic               irq_n_q;

    irq_sync #(
        .WIDTH (NUM_SRC),
        .DEPTH (SYNC_LEN)
    ) u_sync (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .async_n_i (src_irq_n_i),
        .sync_n_o  (w_synced_n)
    );

    assign w_raw_src = ~w_synced_n;
    assign w_raw     = MAX_SRC'(w_raw_src);

    // A CPU write is held for many clocks; only its first cycle commits.
    assign w_wr_act = ~cs_n_i & ~rw_i;
    assign w_commit = w_wr_act & ~wr_act_q;

`ifdef IRQ_CTRL_EDGE_EN
    logic [MAX_SRC-1:0] edge_q;
    logic [MAX_SRC-1:0] edge_d;
    logic [MAX_SRC-1:0] raw_prev_q;
    logic [MAX_SRC-1:0] w_fall;
    logic [MAX_SRC-1:0] w_w1c;

    assign w_fall = w_raw & ~raw_prev_q;

    always_comb begin
        w_w1c  = '0;
        edge_d = edge_q;
        if (w_commit && (addr_i == IRQ_REG_PENDING)) begin
            w_w1c = wdata_i & SRC_VALID;
        end
        if (w_commit && (addr_i == IRQ_REG_EDGE)) begin
            edge_d = wdata_i & SRC_VALID;
        end
        // A fresh edge outranks a simultaneous W1C of the same bit.
        pending_d = (edge_q & (w_fall | (pending_q & ~w_w1c)))
                  | (~edge_q & w_raw);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            edge_q     <= '0;
            raw_prev_q <= '0;
        end else begin
            edge_q     <= edge_d;
            raw_prev_q <= w_raw;
        end
    end
`else
    assign pending_d = w_raw;
`endif

    always_comb begin
        mask_d = mask_q;
        if (w_commit && (addr_i == IRQ_REG_MASK)) begin
            mask_d = wdata_i & SRC_VALID;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_act_q  <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            irq_n_q   <= 1'b1;
        end else begin
            wr_act_q  <= w_wr_act;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            irq_n_q   <= ~|(pending_q & mask_q);
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (addr_i)
            IRQ_REG_STATUS:  w_rdata = w_raw;
            IRQ_REG_PENDING: w_rdata = pending_q;
            IRQ_REG_MASK:    w_rdata = mask_q;
            IRQ_REG_VECTOR:  w_rdata = irq_vector(pending_q & mask_q);
`ifdef IRQ_CTRL_EDGE_EN
            IRQ_REG_EDGE:    w_rdata = edge_q;
`else
            IRQ_REG_EDGE:    w_rdata = 8'h00;
`endif
            default:         w_rdata = 8'h00;
        endcase
    end

    assign rdata_oe_o = ~cs_n_i & rw_i;
    assign rdata_o    = rdata_oe_o ? w_rdata : 8'h00;
    assign irq_n_o    = irq_n_q;

endmodule
`default_nettype wire
